// File: rtl/ghost_step_driver_if.sv
// ghost_step_driver_if
//   Step handshake between a ghost step driver (master) and its ghost AI /
//   game-top environment (slave).
//
//   Handshake: move_tick, power_pellet and ghost_eaten are single-cycle
//   pulses with no back-pressure; the master absorbs them (a tick that
//   arrives while busy is queued one deep). The master presents
//   currentloc/currentfacing/mode/rotate and holds update high for the
//   whole DRIVE window. These four are stable from DRIVE entry until
//   capture. The slave must have nextloc/nextfacing valid by the capture
//   cycle, which is flagged by step_done.
//
//   Signals:
//     move_tick, power_pellet, ghost_eaten   slave -> master pulses
//     nextloc[15:0], nextfacing[15:0]        slave -> master AI result
//     currentloc[15:0], currentfacing[15:0]  master -> slave ghost state
//     mode[3:0], rotate                      master -> slave behaviour
//     update, busy, step_done                master -> slave step status
interface ghost_step_driver_if;
   logic        move_tick;
   logic        power_pellet;
   logic        ghost_eaten;
   logic [15:0] nextloc;
   logic [15:0] nextfacing;
   logic [15:0] currentloc;
   logic [15:0] currentfacing;
   logic [3:0]  mode;
   logic        rotate;
   logic        update;
   logic        busy;
   logic        step_done;

   modport master (
      input  move_tick, power_pellet, ghost_eaten, nextloc, nextfacing,
      output currentloc, currentfacing, mode, rotate, update, busy, step_done
   );

   modport slave (
      output move_tick, power_pellet, ghost_eaten, nextloc, nextfacing,
      input  currentloc, currentfacing, mode, rotate, update, busy, step_done
   );
endinterface

// File: rtl/ghost_step_driver.sv
// ghost_step_driver
//   Requesting side of one ghost AI's step handshake. It owns the ghost's
//   location and facing and sequences IDLE -> DRIVE -> SETTLE -> CAPTURE per
//   step. It also runs the Scatter/Chase schedule, the Frightened timer and
//   the Eaten return-home logic.
//
//   Ports:
//     sysclk     clock, rising edge
//     reset      synchronous, active-high
//     bus        ghost_step_driver_if.master (handshake, see interface file)
//     dbg_state  current step FSM state (0 IDLE, 1 DRIVE, 2 SETTLE, 3 CAPTURE)
module ghost_step_driver #(
   parameter logic [15:0] START_LOC     = 16'h656A,
   parameter logic [15:0] START_FACING  = 16'hFF00,
   parameter int unsigned SCATTER_STEPS = 7,
   parameter int unsigned CHASE_STEPS   = 20,
   parameter int unsigned FRIGHT_STEPS  = 6,
   parameter int unsigned UPD_CYCLES    = 8,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                        sysclk,
   input  logic                        reset,
   ghost_step_driver_if.master         bus,
   output logic [1:0]                  dbg_state
);

   localparam logic [3:0] M_CHASE   = 4'b1000;
   localparam logic [3:0] M_SCATTER = 4'b0100;
   localparam logic [3:0] M_FRIGHT  = 4'b0010;
   localparam logic [3:0] M_EATEN   = 4'b0001;

   localparam logic [7:0] SCAT_N   = 8'(SCATTER_STEPS);
   localparam logic [7:0] CHASE_N  = 8'(CHASE_STEPS);
   localparam logic [7:0] FRIGHT_N = 8'(FRIGHT_STEPS);
   localparam logic [7:0] UPD_N    = 8'(UPD_CYCLES);
   localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cyc_q;
   logic        pend_q;
   logic [15:0] loc_q, face_q;

   logic [3:0]  mode_q, mode_d;
   logic        rotate_q, rotate_d;
   logic [7:0]  step_cnt_q, step_cnt_d;
   logic [7:0]  fright_q, fright_d;
   logic        base_chase_q, base_chase_d;
   logic        pel_flag_q, pel_flag_d;
   logic        eat_flag_q, eat_flag_d;

   logic        start;
   assign start = bus.move_tick || pend_q;

   // ---------------- step FSM: state register ----------------
   always_ff @(posedge sysclk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- step FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start)       state_d = S_DRIVE;
         S_DRIVE:   if (cyc_q <= 8'd1) state_d = S_SETTLE;
         S_SETTLE:  if (cyc_q <= 8'd1) state_d = S_CAPTURE;
         S_CAPTURE:                  state_d = S_IDLE;
         default:                    state_d = S_IDLE;
      endcase
   end

   // ---------------- step FSM: outputs ----------------
   always_comb begin
      bus.update    = (state_q == S_DRIVE);
      bus.busy      = (state_q != S_IDLE);
      bus.step_done = (state_q == S_CAPTURE);
   end

   assign dbg_state = state_q;

   // Phase cycle counter and one-deep tick queue.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         cyc_q  <= 8'd0;
         pend_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE:   if (start) cyc_q <= UPD_N;
            S_DRIVE:  cyc_q <= (cyc_q <= 8'd1) ? SETTLE_N : cyc_q - 8'd1;
            S_SETTLE: cyc_q <= (cyc_q == 8'd0) ? 8'd0 : cyc_q - 8'd1;
            default:  cyc_q <= 8'd0;
         endcase
         // IDLE always consumes the queued tick as it starts the next step.
         if (state_q == S_IDLE)  pend_q <= 1'b0;
         else if (bus.move_tick) pend_q <= 1'b1;
      end
   end

   // Location/facing capture.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         loc_q  <= START_LOC;
         face_q <= START_FACING;
      end else if (state_q == S_CAPTURE) begin
         loc_q  <= bus.nextloc;
         face_q <= bus.nextfacing;
      end
   end

   // ---------------- mode bookkeeping ----------------
   logic pel, eat, is_base, event_taken;
   logic [7:0] cnt_inc, cnt_lim, fright_dec;
   assign pel        = pel_flag_q || bus.power_pellet;
   assign eat        = eat_flag_q || bus.ghost_eaten;
   assign is_base    = (mode_q == M_SCATTER) || (mode_q == M_CHASE);
   assign cnt_inc    = (step_cnt_q == 8'hFF) ? 8'hFF : step_cnt_q + 8'd1;
   assign cnt_lim    = (mode_q == M_CHASE) ? CHASE_N : SCAT_N;
   assign fright_dec = (fright_q == 8'd0) ? 8'd0 : fright_q - 8'd1;

   always_comb begin
      mode_d       = mode_q;
      rotate_d     = rotate_q;
      step_cnt_d   = step_cnt_q;
      fright_d     = fright_q;
      base_chase_d = base_chase_q;
      pel_flag_d   = pel_flag_q;
      eat_flag_d   = eat_flag_q;
      event_taken  = 1'b0;

      if (state_q == S_DRIVE || state_q == S_SETTLE) begin
         // Mode is frozen mid-step; remember events for the capture.
         pel_flag_d = pel;
         eat_flag_d = eat;
      end else begin
         pel_flag_d = 1'b0;
         eat_flag_d = 1'b0;
         if (state_q == S_CAPTURE) rotate_d = 1'b0;

         // Eaten beats a simultaneous pellet; the pellet is discarded.
         if (mode_q == M_FRIGHT && eat) begin
            mode_d      = M_EATEN;
            event_taken = 1'b1;
         end else if (pel && is_base) begin
            base_chase_d = (mode_q == M_CHASE);
            mode_d       = M_FRIGHT;
            fright_d     = FRIGHT_N;
            rotate_d     = 1'b1;
            event_taken  = 1'b1;
         end else if (pel && mode_q == M_FRIGHT) begin
            fright_d    = FRIGHT_N;
            event_taken = 1'b1;
         end

         // A step that applied an event does not also advance the schedule.
         if (state_q == S_CAPTURE && !event_taken) begin
            if (is_base) begin
               if (cnt_inc >= cnt_lim) begin
                  mode_d     = (mode_q == M_CHASE) ? M_SCATTER : M_CHASE;
                  step_cnt_d = 8'd0;
                  rotate_d   = 1'b1;
               end else begin
                  step_cnt_d = cnt_inc;
               end
            end else if (mode_q == M_FRIGHT) begin
               fright_d = fright_dec;
               if (fright_dec == 8'd0)
                  mode_d = base_chase_q ? M_CHASE : M_SCATTER;
            end else if (mode_q == M_EATEN) begin
               if (bus.nextloc == START_LOC)
                  mode_d = base_chase_q ? M_CHASE : M_SCATTER;
            end
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         mode_q       <= M_SCATTER;
         rotate_q     <= 1'b0;
         step_cnt_q   <= 8'd0;
         fright_q     <= 8'd0;
         base_chase_q <= 1'b0;
         pel_flag_q   <= 1'b0;
         eat_flag_q   <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         rotate_q     <= rotate_d;
         step_cnt_q   <= step_cnt_d;
         fright_q     <= fright_d;
         base_chase_q <= base_chase_d;
         pel_flag_q   <= pel_flag_d;
         eat_flag_q   <= eat_flag_d;
      end
   end

   assign bus.currentloc    = loc_q;
   assign bus.currentfacing = face_q;
   assign bus.mode          = mode_q;
   assign bus.rotate        = rotate_q;

endmodule

// File: tb/tb_ghost_step_driver.sv
// tb_ghost_step_driver
//   Directed bench for ghost_step_driver. Cycle k of a step is the clock
//   period ending at rising edge k, where edge 0 samples move_tick. Outputs
//   are sampled on the falling edge inside that period.
module tb_ghost_step_driver;

   logic       sysclk;
   logic       reset;
   logic [1:0] dbg_state;

   int vectors;
   int miscompares;

   logic       mid_rotate;
   logic [3:0] mid_mode;

   ghost_step_driver_if bus ();

   ghost_step_driver dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge sysclk);
      reset = 1'b1;
      repeat (2) @(posedge sysclk);
      @(negedge sysclk);
      reset = 1'b0;
   endtask

   // One full step: tick at edge 0, optional pulses in given cycles, ends in
   // cycle 12 (idle again). Records rotate in cycle 5 and mode in cycle 10.
   task automatic run_step(input logic [15:0] nloc, input int pel_cyc,
                           input int eat_cyc);
      bus.nextloc   = nloc;
      bus.move_tick = 1'b1;
      @(posedge sysclk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge sysclk);
         bus.move_tick    = 1'b0;
         bus.power_pellet = (k == pel_cyc);
         bus.ghost_eaten  = (k == eat_cyc);
         if (k == 5)  mid_rotate = bus.rotate;
         if (k == 10) mid_mode   = bus.mode;
      end
      bus.power_pellet = 1'b0;
      bus.ghost_eaten  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      vectors++;
      if (bus.currentloc !== 16'h656A) begin
         miscompares++; $display("FAIL reset_loc got %h want 656a", bus.currentloc);
      end
      vectors++;
      if (bus.currentfacing !== 16'hFF00) begin
         miscompares++; $display("FAIL reset_facing got %h want ff00", bus.currentfacing);
      end
      vectors++;
      if (bus.mode !== 4'b0100) begin
         miscompares++; $display("FAIL reset_mode got %b want 0100", bus.mode);
      end
      vectors++;
      if ({bus.rotate, bus.update, bus.busy, bus.step_done} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_bits got %b want 0000",
                  {bus.rotate, bus.update, bus.busy, bus.step_done});
      end
      vectors++;
      if (dbg_state !== 2'd0) begin
         miscompares++; $display("FAIL reset_state got %0d want 0", dbg_state);
      end
   endtask

   task automatic test_first_step();
      apply_reset();
      bus.nextloc    = 16'h646A;
      bus.nextfacing = 16'hFF00;
      bus.move_tick  = 1'b1;
      @(posedge sysclk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge sysclk);
         bus.move_tick = 1'b0;
         vectors++;
         if (bus.update !== (k <= 8)) begin
            miscompares++; $display("FAIL step_update cycle %0d got %b want %b", k, bus.update, (k <= 8));
         end
         vectors++;
         if (bus.busy !== (k <= 11)) begin
            miscompares++; $display("FAIL step_busy cycle %0d got %b want %b", k, bus.busy, (k <= 11));
         end
         vectors++;
         if (bus.step_done !== (k == 11)) begin
            miscompares++; $display("FAIL step_done cycle %0d got %b want %b", k, bus.step_done, (k == 11));
         end
      end
      vectors++;
      if (bus.currentloc !== 16'h646A) begin
         miscompares++; $display("FAIL step_loc got %h want 646a", bus.currentloc);
      end
   endtask

   task automatic test_scatter_to_chase();
      apply_reset();
      bus.nextfacing = 16'h0100;
      for (int s = 1; s <= 7; s++) begin
         run_step(16'h1000, 0, 0);
         vectors++;
         if (bus.mode !== ((s == 7) ? 4'b1000 : 4'b0100)) begin
            miscompares++; $display("FAIL sched_mode step %0d got %b", s, bus.mode);
         end
         vectors++;
         if (bus.rotate !== (s == 7)) begin
            miscompares++; $display("FAIL sched_rotate step %0d got %b want %b", s, bus.rotate, (s == 7));
         end
      end
      run_step(16'h1001, 0, 0);
      vectors++;
      if (mid_rotate !== 1'b1) begin
         miscompares++; $display("FAIL step8_mid_rotate got %b want 1", mid_rotate);
      end
      vectors++;
      if (bus.rotate !== 1'b0 || bus.mode !== 4'b1000) begin
         miscompares++; $display("FAIL step8_after got rot %b mode %b want 0 1000", bus.rotate, bus.mode);
      end
      vectors++;
      if (bus.currentfacing !== 16'h0100) begin
         miscompares++; $display("FAIL facing_capture got %h want 0100", bus.currentfacing);
      end
   endtask

   // Continues from Chase with one chase step already counted.
   task automatic test_pellet_in_chase();
      run_step(16'h2000, 3, 0);
      vectors++;
      if (mid_mode !== 4'b1000) begin
         miscompares++; $display("FAIL pellet_mid_mode got %b want 1000", mid_mode);
      end
      vectors++;
      if (bus.mode !== 4'b0010 || bus.rotate !== 1'b1) begin
         miscompares++; $display("FAIL pellet_fright got mode %b rot %b want 0010 1", bus.mode, bus.rotate);
      end
      for (int s = 1; s <= 6; s++) begin
         run_step(16'h2001, 0, 0);
         vectors++;
         if (bus.mode !== ((s == 6) ? 4'b1000 : 4'b0010)) begin
            miscompares++; $display("FAIL fright_step %0d got %b", s, bus.mode);
         end
      end
      vectors++;
      if (bus.rotate !== 1'b0) begin
         miscompares++; $display("FAIL fright_exit_rotate got %b want 0", bus.rotate);
      end
      // Chase count resumes at 1, so 19 more steps reach 20.
      for (int s = 1; s <= 19; s++) begin
         run_step(16'h2002, 0, 0);
         vectors++;
         if (bus.mode !== ((s == 19) ? 4'b0100 : 4'b1000)) begin
            miscompares++; $display("FAIL chase_resume step %0d got %b", s, bus.mode);
         end
      end
      vectors++;
      if (bus.rotate !== 1'b1) begin
         miscompares++; $display("FAIL chase_end_rotate got %b want 1", bus.rotate);
      end
   endtask

   // Continues from Scatter.
   task automatic test_fright_eaten();
      run_step(16'h3000, 0, 0);
      @(negedge sysclk);
      bus.ghost_eaten = 1'b1;
      @(negedge sysclk);
      bus.ghost_eaten = 1'b0;
      vectors++;
      if (bus.mode !== 4'b0100) begin
         miscompares++; $display("FAIL eaten_in_base got %b want 0100", bus.mode);
      end
      bus.power_pellet = 1'b1;
      @(negedge sysclk);
      bus.power_pellet = 1'b0;
      vectors++;
      if (bus.mode !== 4'b0010 || bus.rotate !== 1'b1) begin
         miscompares++; $display("FAIL idle_pellet got mode %b rot %b want 0010 1", bus.mode, bus.rotate);
      end
      run_step(16'h646A, 2, 2);
      vectors++;
      if (bus.mode !== 4'b0001 || bus.rotate !== 1'b0) begin
         miscompares++; $display("FAIL both_events got mode %b rot %b want 0001 0", bus.mode, bus.rotate);
      end
      run_step(16'h646B, 0, 0);
      vectors++;
      if (bus.mode !== 4'b0001) begin
         miscompares++; $display("FAIL eaten_away got %b want 0001", bus.mode);
      end
      run_step(16'h656A, 0, 0);
      vectors++;
      if (bus.mode !== 4'b0100 || bus.currentloc !== 16'h656A) begin
         miscompares++; $display("FAIL eaten_home got mode %b loc %h want 0100 656a", bus.mode, bus.currentloc);
      end
   endtask

   task automatic test_back_to_back();
      int done_n;
      int first_c;
      int second_c;
      done_n = 0; first_c = 0; second_c = 0;
      apply_reset();
      bus.nextloc   = 16'h1234;
      bus.move_tick = 1'b1;
      @(posedge sysclk);
      for (int k = 1; k <= 36; k++) begin
         @(negedge sysclk);
         bus.move_tick = (k == 3) || (k == 6);
         if (bus.step_done === 1'b1) begin
            done_n++;
            if (done_n == 1) first_c = k;
            if (done_n == 2) second_c = k;
         end
      end
      bus.move_tick = 1'b0;
      vectors++;
      if (done_n !== 2) begin
         miscompares++; $display("FAIL b2b_count got %0d want 2", done_n);
      end
      vectors++;
      if (first_c !== 11 || second_c !== 23) begin
         miscompares++; $display("FAIL b2b_cycles got %0d,%0d want 11,23", first_c, second_c);
      end
      vectors++;
      if (bus.busy !== 1'b0 || bus.currentloc !== 16'h1234) begin
         miscompares++; $display("FAIL b2b_end got busy %b loc %h want 0 1234", bus.busy, bus.currentloc);
      end
   endtask

   task automatic test_reset_mid_step();
      int done_n;
      done_n = 0;
      bus.nextloc   = 16'h4321;
      bus.move_tick = 1'b1;
      @(posedge sysclk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge sysclk);
         bus.move_tick = 1'b0;
      end
      reset = 1'b1;
      @(negedge sysclk);
      reset = 1'b0;
      vectors++;
      if (bus.update !== 1'b0 || bus.busy !== 1'b0) begin
         miscompares++; $display("FAIL midreset_update got upd %b busy %b want 0 0", bus.update, bus.busy);
      end
      vectors++;
      if (bus.currentloc !== 16'h656A) begin
         miscompares++; $display("FAIL midreset_loc got %h want 656a", bus.currentloc);
      end
      for (int k = 0; k < 14; k++) begin
         @(negedge sysclk);
         if (bus.step_done === 1'b1) done_n++;
      end
      vectors++;
      if (done_n !== 0 || bus.currentloc !== 16'h656A) begin
         miscompares++; $display("FAIL midreset_nocapture got dones %0d loc %h want 0 656a", done_n, bus.currentloc);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      vectors          = 0;
      miscompares      = 0;
      mid_rotate       = 1'b0;
      mid_mode         = 4'b0;
      reset            = 1'b1;
      bus.move_tick    = 1'b0;
      bus.power_pellet = 1'b0;
      bus.ghost_eaten  = 1'b0;
      bus.nextloc      = 16'h0000;
      bus.nextfacing   = 16'hFF00;

      test_reset();
      test_first_step();
      test_scatter_to_chase();
      test_pellet_in_chase();
      test_fright_eaten();
      test_back_to_back();
      test_reset_mid_step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ghost_step_driver.md
# ghost_step_driver

Controller on the requesting end of a ghost AI module's step handshake. It owns the ghost's registered location and facing, and sequences each movement step. For each step it presents current location, facing, mode and rotate, holds `update` high long enough for the AI pipeline to compute a move, then captures the AI's `nextloc`/`nextfacing`. It also runs the Scatter/Chase schedule, the Frightened timer and the Eaten return-home logic. One instance sits beside each ghost AI under the game top level.

## Interface
Parameters:
- `START_LOC`, 16'h656A, reset/home location {x[15:8]=101, y[7:0]=106}.
- `START_FACING`, 16'hFF00, reset facing (LEFT).
- `SCATTER_STEPS`, 7, completed steps spent in Scatter before switching to Chase.
- `CHASE_STEPS`, 20, completed steps spent in Chase before switching to Scatter.
- `FRIGHT_STEPS`, 6, completed steps spent in Frightened.
- `UPD_CYCLES`, 8, cycles `update` is held high per step (must be ≥7).
- `SETTLE_CYCLES`, 2, cycles between `update` falling and capture.

Ports:
- `sysclk` in 1: the block's single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `move_tick` in 1: one-cycle request to perform one step.
- `power_pellet` in 1: one-cycle pulse; Pac-Man ate a power pellet.
- `ghost_eaten` in 1: one-cycle pulse; Pac-Man collided with this ghost.
- `nextloc` in 16: location result from the AI.
- `nextfacing` in 16: facing result from the AI.
- `currentloc` out 16: registered ghost location {x,y}.
- `currentfacing` out 16: registered facing. Encodings: LEFT FF00, RIGHT 0100, UP 00FF, DOWN 0001.
- `mode` out 4: one-hot mode. Chase 1000, Scatter 0100, Frightened 0010, Eaten 0001.
- `rotate` out 1: reverse-direction request for the current step.
- `update` out 1: step strobe to the AI.
- `busy` out 1: high while a step is in flight.
- `step_done` out 1: one-cycle pulse when a step is captured.

## Operation
- Step FSM has four states: IDLE, DRIVE, SETTLE, CAPTURE.
  - IDLE, with `move_tick` or a pending tick present: go to DRIVE and load the cycle counter with UPD_CYCLES.
  - DRIVE: `update`=1; decrement the counter; at 1, go to SETTLE and load SETTLE_CYCLES.
  - SETTLE: `update`=0; decrement; at 1, go to CAPTURE.
  - CAPTURE (one cycle): `currentloc`<=`nextloc`, `currentfacing`<=`nextfacing`, `step_done`=1, run mode bookkeeping, clear `rotate`; go to IDLE.
- `move_tick` arriving while busy sets a one-deep pending flag. Further ticks while pending are dropped.
- `currentloc`, `currentfacing`, `mode` and `rotate` are constant from DRIVE entry through SETTLE.
- Mode bookkeeping happens only in CAPTURE, or in IDLE when an event is present.
  - `power_pellet` and `ghost_eaten` pulses arriving during DRIVE/SETTLE are held in sticky flags until applied.
  - Base schedule: Scatter/Chase alternate. A step counter increments at each CAPTURE in the base modes. On reaching SCATTER_STEPS or CHASE_STEPS, toggle the mode, clear the counter and set `rotate`.
  - Pellet in Scatter/Chase: save the base mode (step counter frozen), mode=Frightened, load the fright counter with FRIGHT_STEPS, set `rotate`.
  - Pellet in Frightened: reload FRIGHT_STEPS; no rotate.
  - Pellet in Eaten: ignored.
  - Frightened: the fright counter decrements each CAPTURE. At 0, restore the saved base mode and resume its counter; no rotate.
  - `ghost_eaten` in Frightened: mode=Eaten, rotate not set. In any other mode it is ignored.
  - Eaten: after a CAPTURE where the captured location equals START_LOC, restore the saved base mode.
  - Pellet and eaten flags pending together in Frightened: eaten wins and the pellet is discarded.
- Counter widths: 8 bits, saturating, never wrapping.

## Timing
- Reset values: `currentloc`=START_LOC, `currentfacing`=START_FACING, `mode`=0100, all single-bit outputs 0, all counters and flags 0, FSM=IDLE.
- Reset asserted mid-step aborts immediately. `update` is 0 on the cycle after the reset edge, and no capture occurs.
- Cycle numbering: `move_tick` is sampled in IDLE at edge 0.
  - `update` and `busy` are high from edge 1 through edge UPD_CYCLES.
  - `update` is low for SETTLE_CYCLES cycles.
  - CAPTURE at edge 1+UPD_CYCLES+SETTLE_CYCLES (default 11): new `currentloc` and `step_done`=1.
  - `busy` falls at edge 12.
- A pending tick starts the next DRIVE on the cycle after CAPTURE, giving a 12-cycle step period back-to-back.
- `rotate` set at a CAPTURE is visible during the whole next step and cleared at that step's CAPTURE.

## Test plan
- Reset, then `move_tick` with AI `nextloc`=16'h646A, `nextfacing`=FF00: `update` is high for cycles 1–8. At cycle 11, `currentloc`=646A and `step_done` pulses. `busy` is low at cycle 12.
- 7 ticks in Scatter: mode becomes 1000 at the 7th CAPTURE; `rotate`=1 during step 8 and 0 after it.
- `power_pellet` during DRIVE of a Chase step: mode stays 1000 until that CAPTURE, then becomes 0010 with `rotate`=1. After 6 more steps mode returns to 1000 with the chase count resumed.
- Frightened, `power_pellet` and `ghost_eaten` in the same cycle: mode becomes 0001, no rotate. Steps continue until `nextloc`=656A is captured, then mode returns to the saved base mode.
- Three `move_tick` pulses within one step: exactly two steps complete, with CAPTUREs at cycles 11 and 23. Reset at cycle 5 of a step: `update` drops, `currentloc`=656A, and no `step_done` pulse occurs.
